// File: rtl/subneg_bus_pkg.sv
// Shared constants and types for the subneg external memory bus.
package subneg_bus_pkg;

    localparam int BUS_W = 8;

    // Memory-mapped display port address (used when SUBNEG_MEM_DISPLAY_EN is defined)
    localparam logic [BUS_W-1:0] DISPLAY_ADDR = 8'd21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/subneg_mem_array.sv
// DEPTH x AW flop array: loader write port (wins on collision), CPU write
// port, one asynchronous read port, synchronous clear on reset.
// Out-of-range addresses are ignored on every port (reads return zero).
module subneg_mem_array
    import subneg_bus_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = BUS_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [AW-1:0] ld_data,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [AW-1:0] cpu_data,
    input  logic [AW-1:0] rd_addr,
    output logic [AW-1:0] rd_data
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] mem_q, mem_d;
    logic ld_ok, cpu_ok, rd_ok;

    assign ld_ok  = {1'b0, ld_addr}  < DEPTH_W;
    assign cpu_ok = {1'b0, cpu_addr} < DEPTH_W;
    assign rd_ok  = {1'b0, rd_addr}  < DEPTH_W;

    // Next array contents: CPU write first, loader applied last so it wins
    always_comb begin
        mem_d = mem_q;
        if (cpu_we && cpu_ok) mem_d[cpu_addr[IW-1:0]] = cpu_data;
        if (ld_we && ld_ok)   mem_d[ld_addr[IW-1:0]]  = ld_data;
    end

    // Array storage with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    assign rd_data = rd_ok ? mem_q[rd_addr[IW-1:0]] : '0;

endmodule

// File: rtl/subneg_mem_responder.sv
// Memory-side responder for the subneg multiplexed bus (LE/MOE/MWE).
// Optional feature macro: SUBNEG_MEM_DISPLAY_EN (address 21 becomes a
// display register for CPU accesses; the loader still writes memory).
module subneg_mem_responder
    import subneg_bus_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = BUS_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] bus_in,
    input  logic          le,
    input  logic          moe,
    input  logic          mwe,
    output logic [AW-1:0] bus_out,
    output logic          bus_oe,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [AW-1:0] load_data,
    output logic [AW-1:0] display,
    output logic          err_conflict,
    output logic          err_range
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_conflict_q, err_conflict_d;
    logic          err_range_q, err_range_d;
    logic          conflict, in_range, disp_hit, first_wr, cpu_we, range_hit;
    logic [AW-1:0] mem_rd;
    logic [AW-1:0] display_q;

    assign conflict = (le & moe) | (le & mwe) | (moe & mwe);
    assign in_range = {1'b0, addr_q} < DEPTH_W;
    // First sampled cycle of an mwe pulse is the only one that commits
    assign first_wr = mwe & ~conflict & (state_q != ST_WRITE);
    assign bus_oe   = moe & ~mwe & ~le & ~reset;

`ifdef SUBNEG_MEM_DISPLAY_EN
    logic [AW-1:0] display_d;

    assign disp_hit = (addr_q == DISPLAY_ADDR);

    // Display register captures CPU writes aimed at the display address
    always_comb begin
        display_d = display_q;
        if (first_wr && disp_hit) display_d = bus_in;
    end

    // Display register storage
    always_ff @(posedge clk) begin
        if (reset) display_q <= '0;
        else       display_q <= display_d;
    end
`else
    assign disp_hit  = 1'b0;
    assign display_q = '0;
`endif

    assign cpu_we    = first_wr & in_range & ~disp_hit;
    assign range_hit = (bus_oe | first_wr) & ~in_range & ~disp_hit;

    // Bus sequencing: address latch, read/write phases, post-access increment
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE, ST_ADDR: begin
                if (le)       state_d = ST_ADDR;
                else if (moe) state_d = ST_READ;
                else if (mwe) state_d = ST_WRITE;
                else          state_d = ST_IDLE;
            end
            ST_READ: begin
                if (!moe) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (!mwe) begin
                    state_d = ST_IDLE;
                    addr_d  = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh address always overrides the increment
        if (le) addr_d = bus_in;
        err_conflict_d = err_conflict_q | conflict;
        err_range_d    = err_range_q | range_hit;
    end

    // Control and sticky error state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            err_conflict_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            err_conflict_q <= err_conflict_d;
            err_range_q    <= err_range_d;
        end
    end

    subneg_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk      (clk),
        .reset    (reset),
        .ld_we    (load_we),
        .ld_addr  (load_addr),
        .ld_data  (load_data),
        .cpu_we   (cpu_we),
        .cpu_addr (addr_q),
        .cpu_data (bus_in),
        .rd_addr  (addr_q),
        .rd_data  (mem_rd)
    );

    // Read mux: zero whenever the responder is not driving
    always_comb begin
        bus_out = '0;
        if (bus_oe) bus_out = disp_hit ? display_q : mem_rd;
    end

    assign display      = display_q;
    assign err_conflict = err_conflict_q;
    assign err_range    = err_range_q;

endmodule

// File: tb/tb_subneg_mem_responder.sv
// Randomized transaction-level bench for subneg_mem_responder.
module tb_subneg_mem_responder;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       reset, le, moe, mwe, load_we;
    logic [7:0] bus_in, load_addr, load_data;
    logic [7:0] bus_out, display;
    logic       bus_oe, err_conflict, err_range;

    subneg_mem_responder #(.DEPTH(DEPTH), .AW(8)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .le(le), .moe(moe), .mwe(mwe),
        .bus_out(bus_out), .bus_oe(bus_oe), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .display(display), .err_conflict(err_conflict),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents, current address pointer, flags
    logic [7:0] m_mem [256];
    logic [7:0] m_addr, m_disp;
    logic       m_erng, m_econ;
    int         n_chk = 0, n_err = 0;

`ifdef SUBNEG_MEM_DISPLAY_EN
    localparam bit DISP = 1'b1;
`else
    localparam bit DISP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_disp(input logic [7:0] a);
        return DISP && (a == 8'd21);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (is_disp(a))          return m_disp;
        if (int'(a) < DEPTH)     return m_mem[a];
        return 8'h00;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_addr = 8'h00; m_disp = 8'h00; m_erng = 1'b0; m_econ = 1'b0;
    endtask

    // One bus cycle: drive strobes just after the falling edge
    task automatic step(input logic l, input logic o, input logic w, input logic [7:0] b);
        @(negedge clk);
        le = l; moe = o; mwe = w; bus_in = b; load_we = 1'b0;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_erng"}, err_range, m_erng);
        chk({tag, "_econ"}, err_conflict, m_econ);
        chk({tag, "_disp"}, display, m_disp);
    endtask

    task automatic t_load(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        load_we = 1'b1; load_addr = a; load_data = d;
        if (int'(a) < DEPTH) m_mem[a] = d;
    endtask

    // Address phase, le held two cycles with the last value winning
    task automatic t_latch(input logic [7:0] a);
        step(1'b1, 1'b0, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 1'b0, a);
        m_addr = a;
    endtask

    task automatic t_read(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'($urandom));
            #1;
            chk("rd_oe", bus_oe, 1'b1);
            chk("rd_data", bus_out, m_read(m_addr));
            if (!is_disp(m_addr) && int'(m_addr) >= DEPTH) m_erng = 1'b1;
        end
        step(1'b0, 1'b0, 1'b0, 8'($urandom));
        #1;
        chk("rd_end_oe", bus_oe, 1'b0);
        chk("rd_end_bus", bus_out, 8'h00);
        m_addr = m_addr + 8'd1;
    endtask

    // Write pulse of n cycles; later cycles carry junk that must not land
    task automatic t_write(input int n, input logic [7:0] d, input bit with_load, input logic [7:0] ld);
        step(1'b0, 1'b0, 1'b1, d);
        if (with_load) begin
            load_we = 1'b1; load_addr = m_addr; load_data = ld;
        end
        #1;
        chk("wr_oe", bus_oe, 1'b0);
        chk("wr_bus", bus_out, 8'h00);
        if (is_disp(m_addr))             m_disp = d;
        else if (int'(m_addr) < DEPTH)   m_mem[m_addr] = d;
        else                             m_erng = 1'b1;
        if (with_load && int'(m_addr) < DEPTH) m_mem[m_addr] = ld;
        for (int i = 1; i < n; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 8'($urandom));
        m_addr = m_addr + 8'd1;
    endtask

    task automatic t_conflict(input int kind, input logic [7:0] a);
        case (kind)
            0: step(1'b0, 1'b1, 1'b1, a);
            1: step(1'b1, 1'b1, 1'b0, a);
            default: step(1'b1, 1'b0, 1'b1, a);
        endcase
        #1;
        chk("cf_oe", bus_oe, 1'b0);
        m_econ = 1'b1;
        // moe+mwe enters a read phase that increments on release; with le the address is taken
        if (kind == 0) m_addr = m_addr + 8'd1;
        else           m_addr = a;
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic t_reset();
        @(negedge clk);
        reset = 1'b1; le = 1'b0; moe = 1'b1; mwe = 1'b0; load_we = 1'b0;
        #1;
        chk("rst_oe", bus_oe, 1'b0);
        chk("rst_bus", bus_out, 8'h00);
        @(negedge clk);
        reset = 1'b0; moe = 1'b0;
        m_clear();
        #1;
        chk_flags("rst");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; le = 1'b0; moe = 1'b0; mwe = 1'b0; bus_in = 8'h00;
        load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        m_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_flags("init");
        chk("init_oe", bus_oe, 1'b0);

        // Loader preload then read twice from 4, then continue at 5
        t_load(8'd4, 8'h3C);
        t_load(8'd5, 8'h91);
        t_latch(8'h04);
        t_read(2);
        t_read(1);

        // Long write pulse commits once; neighbour untouched
        t_load(8'd8, 8'h66);
        t_latch(8'h07);
        t_write(3, 8'hA5, 1'b0, 8'h00);
        t_latch(8'h07);
        t_read(2);
        t_read(1);

        // Out-of-range read and address wrap
        t_load(8'd0, 8'h5E);
        t_latch(8'hFF);
        t_read(1);
        t_read(1);
        chk_flags("wrap");

        // Display address write/read
        t_load(8'd21, 8'h13);
        t_latch(8'd21);
        t_write(1, 8'h2A, 1'b0, 8'h00);
        t_latch(8'd21);
        t_read(1);
        chk_flags("disp");

        // Conflicts, then verify no write happened
        t_latch(8'd10);
        t_conflict(0, 8'h77);
        t_latch(8'd10);
        t_read(1);
        t_conflict(2, 8'd12);
        t_read(1);
        chk_flags("conf");

        // Loader beats CPU write to the same address on the same edge
        t_latch(8'd3);
        t_write(2, 8'hB4, 1'b1, 8'hC7);
        t_latch(8'd3);
        t_read(1);

        // Reset in the middle of a write pulse, after its commit edge
        t_latch(8'd9);
        step(1'b0, 1'b0, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b1, 8'h88);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mwe = 1'b0;
        m_clear();
        #1;
        chk_flags("rstwr");
        t_load(8'd0, 8'h11);
        t_load(8'd10, 8'h22);
        t_read(1);
        t_latch(8'd9);
        t_read(1);

        // Randomized transaction mix
        for (int it = 0; it < 400; it++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 15) begin
                t_load(8'($urandom_range(0, DEPTH + 15)), 8'($urandom));
            end else if (sel < 35) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      t_latch(8'hFE + 8'($urandom_range(0, 1)));
                else if (r == 1) t_latch(8'd21);
                else             t_latch(8'($urandom_range(0, DEPTH + 7)));
            end else if (sel < 60) begin
                t_read(int'($urandom_range(1, 3)));
            end else if (sel < 85) begin
                t_write(int'($urandom_range(1, 3)), 8'($urandom),
                        ($urandom_range(0, 7) == 0), 8'($urandom));
            end else if (sel < 93) begin
                t_conflict(int'($urandom_range(0, 2)), 8'($urandom_range(0, DEPTH + 7)));
            end else if (sel < 95) begin
                t_reset();
            end else begin
                step(1'b0, 1'b0, 1'b0, 8'($urandom));
            end
            #1;
            chk_flags("rnd");
        end

        step(1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        chk_flags("final");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/subneg_mem_responder.md
# subneg_mem_responder

Memory-side responder for the subneg CPU's multiplexed external bus. It decodes the LE / MOE / MWE strobes the CPU drives on its uio pins. It latches the address phase, answers read phases by driving data back on the shared bus, and commits write phases into an on-chip word array. It sits on the far side of the CPU's uio interface, either in a companion tile or in the test harness, and includes a host loader port for program preload.

## Interface
- `DEPTH`, default 32: words implemented; addresses ≥ DEPTH are out of range.
- `AW`, default 8: bus and address width; fixed at 8 for the subneg bus.
- `clk` in, 1 bit: single clock, same as the CPU.
- `reset` in, 1 bit: synchronous, active-high.
- `bus_in` in, 8 bits: CPU-driven bus value (address or write data).
- `le` in, 1 bit: address latch enable.
- `moe` in, 1 bit: memory output enable (read).
- `mwe` in, 1 bit: memory write enable.
- `bus_out` out, 8 bits: read data.
- `bus_oe` out, 1 bit: responder drives the bus.
- `load_we` in, 1 bit: host loader write strobe.
- `load_addr` in, 8 bits: host loader address.
- `load_data` in, 8 bits: host loader data.
- `display` out, 8 bits: display register (see Configuration).
- `err_conflict` out, 1 bit: sticky; strobes overlapped.
- `err_range` out, 1 bit: sticky; out-of-range access.

## Operation
- FSM states and transitions, evaluated on each posedge:
  - IDLE: `le` → ADDR; `moe` → READ; `mwe` → WRITE.
  - ADDR: while `le`=1, `addr_q <= bus_in` every cycle. Exits on `le`=0 to IDLE, or directly to READ/WRITE if that strobe is already high.
  - READ: held while `moe`. On `moe` falling, `addr_q <= addr_q+1` (8-bit wrap, 0xFF→0x00), then back to IDLE.
  - WRITE: on the first cycle of the `mwe` pulse, `mem[addr_q] <= bus_in`. This is exactly one write per pulse regardless of pulse length. On `mwe` falling, `addr_q` increments as in READ, then back to IDLE.
- Combinational read path:
  - `bus_oe = moe & ~mwe & ~le`.
  - `bus_out = mem[addr_q]` when in range, else 0x00.
  - `bus_out` = 0x00 whenever `bus_oe`=0.
- Conflicts: any cycle with two or more of {`le`, `moe`, `mwe`} high sets `err_conflict`. That cycle performs no memory write and `bus_oe`=0. If `le` is among the strobes, the address is still latched.
- Range: a read or write with `addr_q` ≥ DEPTH sets `err_range`. Reads return 0x00; writes are dropped.
- Loader: when `load_we`=1, `mem[load_addr] <= load_data` on that edge, in any FSM state. Out-of-range loader writes are dropped silently. If the loader and a CPU write target the same address on the same edge, the loader wins.
- Reset:
  - FSM state, `addr_q` = 0x00, IDLE, all memory words = 0x00.
  - Outputs: `display` = 0x00, `err_*` = 0, `bus_oe` = 0, `bus_out` = 0x00.
  - Reset takes priority over `load_we` and all strobes; an access in progress is abandoned with no write and no increment.

## Timing
- Address phase: `addr_q` is valid on the edge after `le` is sampled high.
- Read latency is zero cycles from the `moe` level. The CPU asserts `moe` at edge k and samples the bus at edge k+1, which is satisfied because the read path is combinational from registered state.
- Write: data is committed at the first edge `mwe`=1 is sampled and is readable from the next cycle.
- Increment: takes effect at the edge where `moe`/`mwe` is first sampled low.
- Error flags assert at the edge following the offending cycle and hold until `reset`.

## Configuration
- Macro: `SUBNEG_MEM_DISPLAY_EN`.
- Defined:
  - Address 0x15 (21) is a memory-mapped display port.
  - CPU writes there load `display` instead of `mem`.
  - CPU reads there return the current `display` value.
  - The loader still writes `mem[21]`.
- Undefined: address 21 is ordinary memory, and `display` is tied to 0x00.

## Structure
- Package `subneg_bus_pkg` holds:
  - the FSM enum {IDLE, ADDR, READ, WRITE};
  - `DISPLAY_ADDR` = 8'd21;
  - the bus width constant.
- Sub-module `subneg_mem_array`: DEPTH×8 flop array with two write ports (loader with priority, then CPU), one async read port, and synchronous clear on `reset`.

## Test plan
- Loader writes 0x3C to address 4; CPU sequence `le` with 0x04, then `moe` for 2 cycles → `bus_oe`=1 and `bus_out`=0x3C while `moe` is high; `addr_q`=0x05 afterwards.
- `le` with 0x07, `mwe` held 3 cycles with `bus_in`=0xA5, then read at 0x07 → 0xA5; `mem[8]` is unchanged.
- `le` with 0xFF, then a read pulse → `bus_out`=0x00, `err_range`=1, and `addr_q` wraps to 0x00.
- `moe` and `mwe` high together for 1 cycle → `err_conflict`=1, no write, `bus_oe`=0.
- With `SUBNEG_MEM_DISPLAY_EN`, CPU write of 0x2A to 21 → `display`=0x2A and `mem[21]` unchanged. Without the macro → `mem[21]`=0x2A and `display`=0x00.
- `reset` asserted mid-WRITE (during the `mwe` pulse, after the commit edge) → state IDLE, `addr_q`=0, memory all 0x00, flags cleared, no increment.
